// File: rtl/wb_lat_ram_pkg.sv
// ==========================================================================
// wb_lat_ram_pkg : shared types and width helpers for the latency RAM model
// Rev 1.0
// ==========================================================================
`default_nettype none

package wb_lat_ram_pkg;

   typedef enum logic [1:0] {
      SVC_IDLE = 2'd0,
      SVC_WAIT = 2'd1,
      SVC_RESP = 2'd2,
      SVC_GAP  = 2'd3
   } svc_state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int SEL_WIDTH      = DEF_DATA_WIDTH / 8;
   localparam int REQ_WIDTH      = DEF_ADDR_WIDTH + DEF_DATA_WIDTH + SEL_WIDTH + 1;

   function automatic int sel_width(input int dw);
      return dw / 8;
   endfunction

   // Queue entry layout is {adr, dat, sel, we}
   function automatic int req_width(input int aw, input int dw);
      return aw + dw + (dw / 8) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ==========================================================================
// sync_fifo : single-clock FIFO with synchronous flush
// Rev 1.1
// ==========================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign dout_o  = mem[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem[wr_ptr_q] <= din_i;
   end

endmodule

`default_nettype wire

// File: rtl/wb_lat_ram_mem.sv
// ==========================================================================
// wb_lat_ram_mem : byte-enabled synchronous single-port word array
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_lat_ram_mem
   import wb_lat_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int MEM_WORDS  = 256
) (
   input  logic                               clk_i,
   input  logic                               en_i,
   input  logic                               we_i,
   input  logic [sel_width(DATA_WIDTH)-1:0]   sel_i,
   input  logic [ADDR_WIDTH-1:0]              adr_i,
   input  logic [DATA_WIDTH-1:0]              wdat_i,
   output logic [DATA_WIDTH-1:0]              rdat_o
);

   localparam int SW = sel_width(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] ram [MEM_WORDS];
   logic [DATA_WIDTH-1:0] rdat_q;

   assign rdat_o = rdat_q;

   // Contents are deliberately left unreset, like real backing memory
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < SW; b++) begin
               if (sel_i[b]) ram[adr_i][8*b +: 8] <= wdat_i[8*b +: 8];
            end
         end else begin
            rdat_q <= ram[adr_i];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_lat_ram.sv
// ==========================================================================
// wb_lat_ram : Wishbone pipelined RAM with programmable latency and gap
// Rev 1.0
// ==========================================================================
`default_nettype none

module wb_lat_ram
   import wb_lat_ram_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int MEM_WORDS   = 256,
   parameter int QUEUE_DEPTH = 4,
   parameter int LATENCY     = 4,
   parameter int ISSUE_GAP   = 0
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [ADDR_WIDTH-1:0]            adr_i,
   input  logic [DATA_WIDTH-1:0]            dat_i,
   input  logic [sel_width(DATA_WIDTH)-1:0] sel_i,
   input  logic                             we_i,
   input  logic                             stb_i,
   input  logic                             cyc_i,
   output logic [DATA_WIDTH-1:0]            dat_o,
   output logic [ADDR_WIDTH-1:0]            tag_o,
   output logic                             ack_o,
   output logic                             err_o,
   output logic                             stall_o
);

   localparam int SW      = sel_width(DATA_WIDTH);
   localparam int RW      = req_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int CNT_MAX = (LATENCY > ISSUE_GAP) ? LATENCY : ISSUE_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

   svc_state_t            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] tag_q, tag_d;
   logic                  rd_ok_q, rd_ok_d;
   logic                  in_range_q, in_range_d;

   logic                  accept, fifo_full, fifo_empty, fifo_pop, fifo_flush, mem_en;
   logic [RW-1:0]         head_word;
   logic [ADDR_WIDTH-1:0] head_adr;
   logic [DATA_WIDTH-1:0] head_dat, mem_rdat;
   logic [SW-1:0]         head_sel;
   logic                  head_we, head_in_range;

   assign accept        = cyc_i && stb_i && !fifo_full;
   assign {head_adr, head_dat, head_sel, head_we} = head_word;
   assign head_in_range = ({1'b0, head_adr} < MEM_LIMIT);

   sync_fifo #(
      .WIDTH (RW),
      .DEPTH (QUEUE_DEPTH)
   ) u_req_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_i),
      .push_i  (accept),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .din_i   ({adr_i, dat_i, sel_i, we_i}),
      .dout_o  (head_word),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   wb_lat_ram_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_WORDS  (MEM_WORDS)
   ) u_mem (
      .clk_i  (clk_i),
      .en_i   (mem_en),
      .we_i   (head_we),
      .sel_i  (head_sel),
      .adr_i  (head_adr),
      .wdat_i (head_dat),
      .rdat_o (mem_rdat)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tag_d      = tag_q;
      rd_ok_d    = rd_ok_q;
      in_range_d = in_range_q;
      mem_en     = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      // A dropped cycle abandons everything queued; an access already made stays made
      if (!cyc_i) begin
         fifo_flush = 1'b1;
         state_d    = SVC_IDLE;
         cnt_d      = '0;
      end else begin
         case (state_q)
            SVC_IDLE: begin
               if (!fifo_empty) begin
                  cnt_d   = CW'(LATENCY - 1);
                  state_d = SVC_WAIT;
               end
            end
            SVC_WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  mem_en     = head_in_range;
                  tag_d      = head_adr;
                  rd_ok_d    = head_in_range && !head_we;
                  in_range_d = head_in_range;
                  state_d    = SVC_RESP;
               end
            end
            SVC_RESP: begin
               fifo_pop = 1'b1;
               if (ISSUE_GAP > 0) begin
                  cnt_d   = CW'(ISSUE_GAP - 1);
                  state_d = SVC_GAP;
               end else begin
                  state_d = SVC_IDLE;
               end
            end
            SVC_GAP: begin
               if (cnt_q == '0) state_d = SVC_IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = SVC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= SVC_IDLE;
         cnt_q      <= '0;
         tag_q      <= '0;
         rd_ok_q    <= 1'b0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tag_q      <= tag_d;
         rd_ok_q    <= rd_ok_d;
         in_range_q <= in_range_d;
      end
   end

   // Read data is gated so writes, errors and reset present zero
   assign dat_o   = rd_ok_q ? mem_rdat : '0;
   assign tag_o   = tag_q;
   assign ack_o   = cyc_i && (state_q == SVC_RESP) && in_range_q;
   assign err_o   = cyc_i && (state_q == SVC_RESP) && !in_range_q;
   assign stall_o = fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_wb_lat_ram.sv
// ==========================================================================
// tb_wb_lat_ram : directed self-checking bench for wb_lat_ram
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_wb_lat_ram;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [7:0]  adr_i;
   logic [31:0] dat_i;
   logic [3:0]  sel_i;
   logic        we_i, stb_i, cyc_i;
   logic [31:0] dat_o;
   logic [7:0]  tag_o;
   logic        ack_o, err_o, stall_o;

   int total = 0;
   int bad   = 0;
   int cyc_cnt = 0;

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  tag;
      logic [31:0] dat;
      logic        ack;
      logic        err;
   } rec_t;

   rec_t rq[$];

   wb_lat_ram #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (8),
      .MEM_WORDS   (200),
      .QUEUE_DEPTH (4),
      .LATENCY     (4),
      .ISSUE_GAP   (0)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .adr_i   (adr_i),
      .dat_i   (dat_i),
      .sel_i   (sel_i),
      .we_i    (we_i),
      .stb_i   (stb_i),
      .cyc_i   (cyc_i),
      .dat_o   (dat_o),
      .tag_o   (tag_o),
      .ack_o   (ack_o),
      .err_o   (err_o),
      .stall_o (stall_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (ack_o || err_o) begin
         rec_t r;
         r.cyc = 32'(cyc_cnt);
         r.tag = tag_o;
         r.dat = dat_o;
         r.ack = ack_o;
         r.err = err_o;
         rq.push_back(r);
      end
      if (ack_o && err_o) begin
         total++;
         bad++;
         $error("FAIL ack_err_both observed=1 expected=0");
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents a request, holds it through any stall, returns its presentation cycle
   task automatic send(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, output int p);
      int g = 0;
      cyc_i = 1'b1; stb_i = 1'b1;
      adr_i = a; dat_i = d; sel_i = s; we_i = w;
      while (stall_o && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         total++;
         bad++;
         $error("FAIL stall_timeout observed=stalled expected=accept");
      end
      p = cyc_cnt;
      @(negedge clk);
   endtask

   task automatic get_resp(output rec_t r);
      int g = 0;
      while (rq.size() == 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      total++;
      assert (rq.size() != 0) else begin
         bad++;
         $error("FAIL resp_timeout observed=none expected=response");
      end
      if (rq.size() != 0) r = rq.pop_front();
      else                r = '0;
   endtask

   // Single isolated transaction: response kind, tag, data and unloaded latency of 6
   task automatic txn(input string nm, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic w, input logic exp_ack,
                      input logic [31:0] exp_dat);
      int   p;
      rec_t r;
      send(a, d, s, w, p);
      stb_i = 1'b0;
      get_resp(r);
      check({nm, "_ack"}, 32'(r.ack), 32'(exp_ack));
      check({nm, "_err"}, 32'(r.err), 32'(!exp_ack));
      check({nm, "_tag"}, 32'(r.tag), 32'(a));
      check({nm, "_dat"}, r.dat, exp_dat);
      check({nm, "_lat"}, 32'(int'(r.cyc) - p), 32'd6);
   endtask

   initial begin
      int   p [6];
      rec_t r [6];
      int   g;
      logic [7:0]  exp_tag [6];
      logic [31:0] exp_dat [6];

      rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      adr_i = '0; dat_i = '0; sel_i = '0;
      repeat (3) @(negedge clk);
      check("rst_ack",   32'(ack_o),   32'd0);
      check("rst_err",   32'(err_o),   32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_dat",   dat_o,        32'd0);
      check("rst_tag",   32'(tag_o),   32'd0);
      rst_i = 1'b1;
      cyc_i = 1'b1;
      @(negedge clk);

      txn("wr3", 8'd3, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 32'h0);
      txn("rd3", 8'd3, 32'h0,        4'hF, 1'b0, 1'b1, 32'hDEADBEEF);

      // Full word, low-lane overwrite, then read-after-write, all back-to-back
      send(8'd5, 32'h11223344, 4'hF, 1'b1, p[0]);
      send(8'd5, 32'h000000AA, 4'h1, 1'b1, p[1]);
      send(8'd5, 32'h0,        4'hF, 1'b0, p[2]);
      stb_i = 1'b0;
      for (int i = 0; i < 3; i++) get_resp(r[i]);
      check("lane_raw_dat", r[2].dat, 32'h112233AA);
      check("lane_gap1", 32'(int'(r[1].cyc) - int'(r[0].cyc)), 32'd6);
      check("lane_gap2", 32'(int'(r[2].cyc) - int'(r[1].cyc)), 32'd6);

      txn("sel0", 8'd5, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b1, 32'h0);
      txn("selA", 8'd5, 32'h5500CC00, 4'hA, 1'b1, 1'b1, 32'h0);
      txn("rd5",  8'd5, 32'h0,        4'hF, 1'b0, 1'b1, 32'h5522CCAA);
      txn("wr50",  8'd50,  32'hCAFEF00D, 4'hF, 1'b1, 1'b1, 32'h0);
      txn("wr199", 8'd199, 32'h01990199, 4'hF, 1'b1, 1'b1, 32'h0);

      // Six reads into a four-deep queue
      exp_tag = '{8'd3, 8'd5, 8'd50, 8'd199, 8'd3, 8'd5};
      exp_dat = '{32'hDEADBEEF, 32'h5522CCAA, 32'hCAFEF00D, 32'h01990199,
                  32'hDEADBEEF, 32'h5522CCAA};
      for (int i = 0; i < 6; i++) begin
         send(exp_tag[i], 32'h0, 4'hF, 1'b0, p[i]);
         if (i == 2) check("stall_after3", 32'(stall_o), 32'd0);
         if (i == 3) check("stall_after4", 32'(stall_o), 32'd1);
      end
      stb_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         get_resp(r[i]);
         check($sformatf("bp%0d_tag", i), 32'(r[i].tag), 32'(exp_tag[i]));
         check($sformatf("bp%0d_dat", i), r[i].dat, exp_dat[i]);
         if (i > 0)
            check($sformatf("bp%0d_space", i), 32'(int'(r[i].cyc) - int'(r[i-1].cyc)), 32'd6);
      end

      txn("errw250", 8'd250, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0);
      txn("errr250", 8'd250, 32'h0,        4'hF, 1'b0, 1'b0, 32'h0);
      txn("errw200", 8'd200, 32'h87654321, 4'hF, 1'b1, 1'b0, 32'h0);
      txn("alias50", 8'd50,  32'h0,        4'hF, 1'b0, 1'b1, 32'hCAFEF00D);

      // Abort during the first WAIT of three queued writes
      send(8'd3,  32'h11111111, 4'hF, 1'b1, p[0]);
      send(8'd5,  32'h22222222, 4'hF, 1'b1, p[1]);
      send(8'd50, 32'h33333333, 4'hF, 1'b1, p[2]);
      cyc_i = 1'b0; stb_i = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_noresp", 32'(rq.size()), 32'd0);
      check("abort_stall",  32'(stall_o),   32'd0);
      cyc_i = 1'b1;
      @(negedge clk);
      txn("ab_rd3",  8'd3,  32'h0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
      txn("ab_rd5",  8'd5,  32'h0, 4'hF, 1'b0, 1'b1, 32'h5522CCAA);
      txn("ab_rd50", 8'd50, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFEF00D);

      // Drop cycle in the RESP cycle of a write: response suppressed, write kept
      send(8'd7, 32'h0BADF00D, 4'hF, 1'b1, p[0]);
      stb_i = 1'b0;
      g = 0;
      while (cyc_cnt < p[0] + 6 && g < 50) begin
         @(posedge clk);
         #1;
         g++;
      end
      cyc_i = 1'b0;
      @(negedge clk);
      check("supp_ack", 32'(ack_o), 32'd0);
      check("supp_err", 32'(err_o), 32'd0);
      @(negedge clk);
      check("supp_noresp", 32'(rq.size()), 32'd0);
      cyc_i = 1'b1;
      @(negedge clk);
      txn("commit7", 8'd7, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0BADF00D);

      // Asynchronous reset between edges while a read sits in WAIT
      send(8'd3, 32'h0, 4'hF, 1'b0, p[0]);
      stb_i = 1'b0;
      @(negedge clk);
      #3 rst_i = 1'b0;
      #1;
      check("arst_ack",   32'(ack_o),   32'd0);
      check("arst_err",   32'(err_o),   32'd0);
      check("arst_stall", 32'(stall_o), 32'd0);
      check("arst_dat",   dat_o,        32'd0);
      check("arst_tag",   32'(tag_o),   32'd0);
      repeat (2) @(negedge clk);
      rst_i = 1'b1;
      repeat (15) @(negedge clk);
      check("arst_noresp", 32'(rq.size()), 32'd0);
      txn("post_rd5", 8'd5, 32'h0, 4'hF, 1'b0, 1'b1, 32'h5522CCAA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
